enc_stage_1: RTL and testbench

- First stage of the extended-Hamming encoder pipeline. Takes an info word plus work mode, computes the Hamming check bits, and emits a systematic codeword with the overall-parity slot zeroed.
- Output feeds the overall-parity stage, which inserts the parity bit at index parity_width-1.
- Upstream uses a valid/ready handshake. A 2-entry output buffer absorbs downstream stalls.

---
 rtl/enc_pkg.sv | 35 +++
 rtl/enc_check_gen.sv | 44 ++++
 rtl/enc_stage_1.sv | 94 +++++++++
 tb/tb_enc_stage_1.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the extended-Hamming encoder pipeline: modes,
// per-mode widths and check-bit mask rows (info bit 0 at mask bit 0).
package enc_pkg;

  typedef enum logic [1:0] {
    MOD_1   = 2'b00,
    MOD_2   = 2'b01,
    MOD_3   = 2'b10,
    MOD_ILL = 2'b11
  } mode_e;

  localparam int unsigned INFO_W_MAX = 26;
  localparam int unsigned CHK_W_MAX  = 5;

  // Indexed by work_mod; entry 3 is the illegal mode.
  localparam int unsigned INFO_W [4] = '{4, 11, 26, 0};
  localparam int unsigned PAR_W  [4] = '{4, 5, 6, 0};
  localparam int unsigned PAD_W  [4] = '{24, 16, 0, 0};

  localparam logic [INFO_W_MAX-1:0] MASK_TBL [4][CHK_W_MAX] = '{
    '{26'b1011, 26'b1101, 26'b1110, 26'b0, 26'b0},
    '{26'b10101011011, 26'b11001101101, 26'b11110001110, 26'b11111110000, 26'b0},
    '{26'b10101010101010110101011011,
      26'b11001100110011011001101101,
      26'b11110000111100011110001110,
      26'b11111111000000011111110000,
      26'b11111111111111100000000000},
    '{26'b0, 26'b0, 26'b0, 26'b0, 26'b0}
  };

  function automatic int unsigned cw_width(input logic [1:0] m);
    return INFO_W[m] + PAR_W[m];
  endfunction

endpackage

// File: rtl/enc_check_gen.sv
// Combinational Hamming check-bit generator: builds the systematic codeword
// with the overall-parity slot zeroed and flags unsupported modes.
module enc_check_gen
  import enc_pkg::*;
#(
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned MAX_INFO_WIDTH     = 26,
  parameter int unsigned AMBA_WORD          = 32
) (
  input  logic [AMBA_WORD-1:0]          info,
  input  logic [1:0]                    work_mod,
  output logic [MAX_CODEWORD_WIDTH-1:0] codeword,
  output logic                          illegal
);

  localparam logic [INFO_W_MAX-1:0] INFO_LIM =
    INFO_W_MAX'((64'd1 << MAX_INFO_WIDTH) - 64'd1);

  logic [INFO_W_MAX-1:0] info_m;
  logic [CHK_W_MAX-1:0]  chk;

  if (AMBA_WORD > INFO_W_MAX) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^info[AMBA_WORD-1:INFO_W_MAX];
  end

  always_comb begin
    illegal = (mode_e'(work_mod) == MOD_ILL) ||
              (cw_width(work_mod) > MAX_CODEWORD_WIDTH);
    info_m  = info[INFO_W_MAX-1:0] & INFO_LIM &
              INFO_W_MAX'((32'd1 << INFO_W[work_mod]) - 32'd1);
    chk = '0;
    for (int unsigned k = 0; k < CHK_W_MAX; k++) begin
      chk[k] = ^(info_m & MASK_TBL[work_mod][k]);
    end
    // Check bits occupy [P-2:0]; the shift leaves bit P-1 clear for parity.
    codeword = '0;
    if (!illegal) begin
      codeword = MAX_CODEWORD_WIDTH'({6'b0, info_m} << PAR_W[work_mod]) |
                 MAX_CODEWORD_WIDTH'(chk);
    end
  end

endmodule

// File: rtl/enc_stage_1.sv
// Encoder stage 1: valid/ready input, check-bit generation at accept time,
// and a 2-entry output FIFO toward the overall-parity stage.
module enc_stage_1
  import enc_pkg::*;
#(
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned MAX_INFO_WIDTH     = 26,
  parameter int unsigned AMBA_WORD          = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [AMBA_WORD-1:0]          info_in,
  input  logic [1:0]                    work_mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic [1:0]                    mod_out,
  output logic                          mode_err
);

  logic [MAX_CODEWORD_WIDTH-1:0] cw;
  logic                          illegal;

  logic [MAX_CODEWORD_WIDTH-1:0] buf_data [2];
  logic [1:0]                    buf_mod  [2];
  logic                          wr_ptr, rd_ptr;
  logic [1:0]                    count, count_nxt;
  logic                          in_ready_q, err_q;
  logic                          push, pop;

  enc_check_gen #(
    .MAX_CODEWORD_WIDTH (MAX_CODEWORD_WIDTH),
    .MAX_INFO_WIDTH     (MAX_INFO_WIDTH),
    .AMBA_WORD          (AMBA_WORD)
  ) u_check_gen (
    .info     (info_in),
    .work_mod (work_mod),
    .codeword (cw),
    .illegal  (illegal)
  );

  always_comb begin
    push      = in_valid && in_ready_q && !flush;
    pop       = (count != 2'd0) && out_ready && !flush;
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      count_nxt = count + {1'b0, push} - {1'b0, pop};
    end
  end

  // in_ready is registered from the next occupancy so it never depends
  // combinationally on out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      count      <= count_nxt;
      in_ready_q <= (count_nxt != 2'd2);
      err_q      <= push && illegal;
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= cw;
      buf_mod[wr_ptr]  <= work_mod;
    end
  end

  always_comb begin
    out_valid = (count != 2'd0);
    data_out  = out_valid ? buf_data[rd_ptr] : '0;
    mod_out   = out_valid ? buf_mod[rd_ptr]  : '0;
    in_ready  = in_ready_q;
    mode_err  = err_q;
  end

endmodule

// File: tb/tb_enc_stage_1.sv
// Directed bench for enc_stage_1 with a positional-Hamming reference model
// and an expected-output queue.
module tb_enc_stage_1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] info_in = '0;
  logic [1:0]  work_mod = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] data_out;
  logic [1:0]  mod_out;
  logic        mode_err;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [31:0] info2 = '0;
  logic [1:0]  mod2 = '0;
  logic        out_valid2;
  logic [7:0]  data2;
  logic [1:0]  mod_out2;
  logic        err2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mod;
  } exp_t;
  exp_t q[$];
  logic last_acc;

  always #5 clk = ~clk;

  enc_stage_1 #(.MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .AMBA_WORD(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .info_in(info_in), .work_mod(work_mod), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .mod_out(mod_out), .mode_err(mode_err)
  );

  enc_stage_1 #(.MAX_CODEWORD_WIDTH(8), .MAX_INFO_WIDTH(4), .AMBA_WORD(32)) dut8 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid2), .in_ready(in_ready2),
    .info_in(info2), .work_mod(mod2), .out_valid(out_valid2), .out_ready(1'b1),
    .data_out(data2), .mod_out(mod_out2), .mode_err(err2)
  );

  // Info bit j sits at the j-th non-power-of-two position; each check bit is
  // the XOR over positions having that position bit set.
  function automatic logic [31:0] model_cw(input logic [1:0] m, input logic [31:0] info,
                                           input int maxw);
    int iw, pw, pos, j;
    logic [5:0] chk;
    case (m)
      2'b00:   begin iw = 4;  pw = 4; end
      2'b01:   begin iw = 11; pw = 5; end
      2'b10:   begin iw = 26; pw = 6; end
      default: return 32'd0;
    endcase
    if (iw + pw > maxw) return 32'd0;
    chk = '0;
    pos = 3;
    j = 0;
    while (j < iw) begin
      if ((pos & (pos - 1)) != 0) begin
        if (info[j]) chk ^= pos[5:0];
        j++;
      end
      pos++;
    end
    return ((info & ((32'd1 << iw) - 32'd1)) << pw) | {26'd0, chk};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: checks head-of-queue before the edge, updates the model,
  // then checks the registered handshake/status outputs after the edge.
  task automatic tick();
    logic acc, pp, exp_err;
    exp_t e;
    acc = in_valid && in_ready && !flush;
    pp  = out_valid && out_ready && !flush;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("data", data_out, q[0].data);
        chk("mod", {30'd0, mod_out}, {30'd0, q[0].mod});
      end
    end
    if (pp && q.size() != 0) void'(q.pop_front());
    exp_err = acc && (work_mod == 2'b11);
    if (acc) begin
      e.data = model_cw(work_mod, info_in, 32);
      e.mod  = work_mod;
      q.push_back(e);
    end
    if (flush) q.delete();
    last_acc = acc;
    @(posedge clk);
    #1;
    chk("mode_err", {31'd0, mode_err}, {31'd0, exp_err});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
  endtask

  task automatic send(input logic [1:0] m, input logic [31:0] info);
    in_valid = 1'b1;
    work_mod = m;
    info_in  = info;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_mod", {30'd0, mod_out}, 32'd0);
    chk("rst_err", {31'd0, mode_err}, 32'd0);
    rst = 1'b1;
    tick();

    // Known codewords
    out_ready = 1'b1;
    send(2'b00, 32'hB);
    chk("tp_b1", data_out, 32'h0000_00B1);
    send(2'b01, 32'h7FF);
    chk("tp_ffef", data_out, 32'h0000_FFEF);
    send(2'b10, 32'h03FF_FFFF);
    chk("tp_ffdf", data_out, 32'hFFFF_FFDF);
    send(2'b00, 32'hFFFF_FFF5);
    tick();
    tick();

    // Stall with three back-to-back words
    out_ready = 1'b0;
    send(2'b01, 32'h0000_0123);
    send(2'b10, 32'h0155_AA33);
    in_valid = 1'b1;
    work_mod = 2'b00;
    info_in  = 32'h6;
    tick();
    chk("c_held", {31'd0, last_acc}, 32'd0);
    chk("full_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    chk("c_accepted", {31'd0, last_acc}, 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("drained", q.size(), 32'd0);
    tick();

    // Continuous stream of mode-10 words
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      work_mod = 2'b10;
      info_in  = $urandom;
      tick();
      chk("stream_rdy", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    tick();

    // Illegal mode on the 32-bit instance
    send(2'b11, 32'hFF);
    chk("ill_data", data_out, 32'd0);
    chk("ill_mod", {30'd0, mod_out}, 32'd3);
    chk("ill_err", {31'd0, mode_err}, 32'd1);
    tick();
    tick();

    // Width-8 instance: mode 01 is out of range, mode 00 is legal
    in_valid2 = 1'b1;
    mod2 = 2'b01;
    info2 = 32'h7FF;
    tick();
    in_valid2 = 1'b0;
    chk("w8_ill_data", {24'd0, data2}, 32'd0);
    chk("w8_ill_mod", {30'd0, mod_out2}, 32'd1);
    chk("w8_ill_err", {31'd0, err2}, 32'd1);
    chk("w8_ill_vld", {31'd0, out_valid2}, 32'd1);
    in_valid2 = 1'b1;
    mod2 = 2'b00;
    info2 = 32'hB;
    tick();
    in_valid2 = 1'b0;
    chk("w8_err_pulse", {31'd0, err2}, 32'd0);
    chk("w8_data", {24'd0, data2}, model_cw(2'b00, 32'hB, 8));
    tick();
    chk("w8_idle", {31'd0, out_valid2}, 32'd0);
    chk("w8_rdy", {31'd0, in_ready2}, 32'd1);

    // Flush a full buffer, with a same-cycle push that must be dropped
    out_ready = 1'b0;
    send(2'b01, 32'h2AA);
    send(2'b00, 32'h9);
    chk("pre_flush_rdy", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    in_valid = 1'b1;
    work_mod = 2'b10;
    info_in = 32'h1234;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_rdy", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();

    // Asynchronous reset while stalled with two entries
    out_ready = 1'b0;
    send(2'b10, 32'h00AB_CDEF);
    send(2'b11, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", data_out, 32'd0);
    chk("arst_mod", {30'd0, mod_out}, 32'd0);
    chk("arst_err", {31'd0, mode_err}, 32'd0);
    chk("arst_rdy", {31'd0, in_ready}, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    send(2'b00, 32'h3);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
